// File: rtl/float_normalizer_iter.sv
// Iterative normalizer: finds the MSB of a 2N-bit magnitude by shifting up to STEP bits per cycle.
// Optional round-to-nearest-even stage enabled by defining FLOAT_NORMALIZER_ROUND_EN.
module float_normalizer_iter #(
    parameter int N    = 4,
    parameter int STEP = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*N-1:0]         A,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           Y,
    output logic [$clog2(2*N):0]   msb_pos,
    output logic                   zero,
    output logic                   sticky
);
    localparam int W  = 2 * N;
    localparam int MW = $clog2(W) + 1;
    localparam int KW = $clog2(STEP + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t          state, state_n;
    logic [W-1:0]    r, r_n, r_sh;
    logic [MW-1:0]   lz, lz_n, pos_n, pos_norm;
    logic [N-1:0]    y_n;
    logic            zero_n, sticky_n;
    logic [KW-1:0]   k;

    // Leading zeros in the top STEP bits, saturating at STEP when the window is empty.
    function automatic logic [KW-1:0] lead_zeros(input logic [STEP-1:0] t);
        lead_zeros = KW'(STEP);
        for (int i = 0; i < STEP; i++)
            if (t[i]) lead_zeros = KW'(STEP - 1 - i);
    endfunction

    assign k        = lead_zeros(r[W-1 -: STEP]);
    assign r_sh     = r << k;
    assign pos_norm = MW'(W - 1) - lz - MW'(k);

`ifdef FLOAT_NORMALIZER_ROUND_EN
    // Bits strictly below the guard; empty (all-zero mask) when N == 2.
    localparam logic [W-1:0] ST_MASK = (W'(1) << (N - 2)) - W'(1);
    logic guard, st;
    assign guard = r[N-2];
    assign st    = |(r & ST_MASK);
`endif

    always_comb begin
        state_n   = state;
        r_n       = r;
        lz_n      = lz;
        y_n       = Y;
        pos_n     = msb_pos;
        zero_n    = zero;
        sticky_n  = sticky;
        in_ready  = (state == IDLE) && !reset;
        out_valid = (state == DONE);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    r_n     = A;
                    lz_n    = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (r == '0) begin
                    zero_n   = 1'b1;
                    y_n      = '0;
                    pos_n    = '0;
                    sticky_n = 1'b0;
                    state_n  = DONE;
                end else if (k < KW'(STEP)) begin
                    // Hidden one lands in the MSB; keep the normalized word for rounding.
                    r_n      = r_sh;
                    pos_n    = pos_norm;
                    y_n      = r_sh[W-2 -: N];
                    sticky_n = |r_sh[N-2:0];
                    zero_n   = 1'b0;
`ifdef FLOAT_NORMALIZER_ROUND_EN
                    state_n  = ROUND;
`else
                    state_n  = DONE;
`endif
                end else begin
                    r_n  = r << STEP;
                    lz_n = lz + MW'(STEP);
                end
            end
`ifdef FLOAT_NORMALIZER_ROUND_EN
            ROUND: begin
                if (guard & (st | Y[0])) begin
                    if (&Y) begin
                        // Mantissa overflow renormalizes to the next power of two.
                        y_n   = '0;
                        pos_n = msb_pos + MW'(1);
                    end else begin
                        y_n = Y + N'(1);
                    end
                end
                sticky_n = guard | st;
                state_n  = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r       <= '0;
            lz      <= '0;
            Y       <= '0;
            msb_pos <= '0;
            zero    <= 1'b0;
            sticky  <= 1'b0;
        end else begin
            r       <= r_n;
            lz      <= lz_n;
            Y       <= y_n;
            msb_pos <= pos_n;
            zero    <= zero_n;
            sticky  <= sticky_n;
        end
    end
endmodule

// File: tb/tb_float_normalizer_iter.sv
// Self-checking bench for float_normalizer_iter (N=4, STEP=2): directed cases, full sweep,
// randomized operands with backpressure, and reset abort.
module tb_float_normalizer_iter;
    localparam int N    = 4;
    localparam int STEP = 2;
    localparam int W    = 2 * N;
    localparam int MW   = $clog2(W) + 1;

    logic          clock, reset, in_valid, in_ready, out_valid, out_ready, zero, sticky;
    logic [W-1:0]  A;
    logic [N-1:0]  Y;
    logic [MW-1:0] msb_pos;

    int checks = 0;
    int errors = 0;

    float_normalizer_iter #(.N(N), .STEP(STEP)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .A(A),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .msb_pos(msb_pos),
        .zero(zero), .sticky(sticky)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: MSB by scanning, fraction by shifting the value under the hidden one.
    function automatic void model(input int a, output int y, output int m, output int z,
                                  output int s, output int lat);
        y = 0; m = 0; z = 0; s = 0; lat = 2;
        if (a == 0) begin
            z = 1;
            return;
        end
        for (int i = 0; i < W; i++) if (((a >> i) & 1) == 1) m = i;
        y   = ((a << N) >> m) & ((1 << N) - 1);
        lat = 1 + (W - m + STEP - 1) / STEP;
`ifdef FLOAT_NORMALIZER_ROUND_EN
        begin
            int g, st;
            g  = (m - N - 1 >= 0) ? ((a >> (m - N - 1)) & 1) : 0;
            st = (m - N - 1 > 0) ? int'((a & ((1 << (m - N - 1)) - 1)) != 0) : 0;
            if (g == 1 && (st == 1 || (y & 1) == 1)) begin
                y = y + 1;
                if (y == (1 << N)) begin
                    y = 0;
                    m = m + 1;
                end
            end
            s   = g | st;
            lat = lat + 1;
        end
`else
        s = (m > N) ? int'((a & ((1 << (m - N)) - 1)) != 0) : 0;
`endif
    endfunction

    // Present one operand from IDLE and wait for the result; leaves time just after the DONE edge.
    task automatic issue(input logic [W-1:0] a);
        int y, m, z, s, lat, edges;
        model(int'(a), y, m, z, s, lat);
        @(negedge clock);
        A = a;
        in_valid = 1'b1;
        chk($sformatf("in_ready_idle a=%0h", a), 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        A = W'($urandom);
        edges = 1;
        while (out_valid !== 1'b1 && edges < 64) begin
            @(posedge clock); #1;
            edges++;
        end
        chk($sformatf("latency a=%0h", a), 32'(edges), 32'(lat));
        chk($sformatf("Y a=%0h", a), 32'(Y), 32'(y));
        chk($sformatf("msb_pos a=%0h", a), 32'(msb_pos), 32'(m));
        chk($sformatf("zero a=%0h", a), 32'(zero), 32'(z));
        chk($sformatf("sticky a=%0h", a), 32'(sticky), 32'(s));
    endtask

    task automatic drain();
        @(posedge clock); #1;
        chk("drain out_valid", 32'(out_valid), 32'd0);
        chk("drain in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [N-1:0]  ys;
        logic [MW-1:0] ms;
        logic          ss, zs;
        int            d;
        clock = 1'b0; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst Y", 32'(Y), 32'd0);
        chk("rst msb_pos", 32'(msb_pos), 32'd0);
        chk("rst zero", 32'(zero), 32'd0);
        chk("rst sticky", 32'(sticky), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("post-rst in_ready", 32'(in_ready), 32'd1);

        issue(8'h80); drain();
        issue(8'h01); drain();
        issue(8'h2D); drain();
        issue(8'h00); drain();
        issue(8'hFF); drain();
        issue(8'h2F); drain();

        for (int i = 0; i < (1 << W); i++) begin
            issue(W'(i));
            drain();
        end

        // Backpressure: outputs frozen, new requests ignored while DONE.
        out_ready = 1'b0;
        issue(8'h2D);
        ys = Y; ms = msb_pos; ss = sticky; zs = zero;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            in_valid = 1'b1;
            A = 8'hFF;
            #1 chk("bp in_ready", 32'(in_ready), 32'd0);
            @(posedge clock); #1;
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp Y", 32'(Y), 32'(ys));
            chk("bp msb_pos", 32'(msb_pos), 32'(ms));
            chk("bp sticky", 32'(sticky), 32'(ss));
            chk("bp zero", 32'(zero), 32'(zs));
        end
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Random operands with random hold-off on out_ready.
        for (int t = 0; t < 40; t++) begin
            d = int'($urandom_range(0, 3));
            out_ready = (d == 0);
            issue(W'($urandom));
            ys = Y; ms = msb_pos;
            for (int c = 0; c < d; c++) begin
                @(posedge clock); #1;
                chk("rnd hold out_valid", 32'(out_valid), 32'd1);
                chk("rnd hold Y", 32'(Y), 32'(ys));
                chk("rnd hold msb_pos", 32'(msb_pos), 32'(ms));
            end
            @(negedge clock);
            out_ready = 1'b1;
            drain();
        end

        // Reset in the middle of SHIFT discards the operation.
        @(negedge clock);
        A = 8'h01;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd0);
        chk("abort Y", 32'(Y), 32'd0);
        chk("abort msb_pos", 32'(msb_pos), 32'd0);
        chk("abort zero", 32'(zero), 32'd0);
        chk("abort sticky", 32'(sticky), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            chk("abort no result", 32'(out_valid), 32'd0);
        end
        issue(8'h80); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
